light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
- Controller that drives the `button` and `sel` inputs of the lights selector datapath: lights counter, RGB converter and white/RGB mux.
- Provides four modes:
  - manual pass-through with synchronised, edge-detected button
  - timed auto-advance of the colour
  - timed white/RGB blink
  - closed-loop seek that pulses `button` until the lights counter reports a requested colour.
- Sits between board inputs and the selector.

Parameters:
- DW, 24, width of the dwell period input and counter.
- SETTLE, 2, cycles waited after each button pulse before sampling `colour_in` (lights register plus converter register).
- MAX_STEPS, 6, button pulses allowed in one seek before error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = sequencer active; 0 = outputs forced to reset values, FSM to IDLE
- mode  in  2  00 MANUAL, 01 AUTO, 10 BLINK, 11 SEEK
- btn_raw  in  1  raw push-button, asynchronous to clk
- sel_in  in  1  user select, used in MANUAL only
- dwell  in  DW  period control; event every dwell+1 cycles
- seek_start  in  1  one-cycle request, honoured in SEEK mode when not busy
- target  in  3  requested colour code for seek
- colour_in  in  3  current colour from lights counter
- button_out  out  1  to selector `button`
- sel_out  out  1  to selector `sel`
- busy  out  1  seek in progress
- done  out  1  one-cycle pulse, seek matched
- err  out  1  sticky seek error; cleared by next accepted seek_start, rst, or enable=0

Behaviour:
- Reset (rst=0, async) and the enable=0 path:
  - Both force button_out=0, sel_out=0 (white), busy=0, done=0, err=0.
  - Both clear the dwell counter, seek step count, synchroniser and FSM state (IDLE).
  - Reset mid-seek aborts with no done.
- btn_raw input stage:
  - Passes through a 2-FF synchroniser, then a rising-edge detector.
  - The edge produces a one-cycle pulse 3 cycles after the raw rise.
- FSM states: IDLE, MANUAL, AUTO, BLINK, SEEK_IDLE, SEEK_WAIT, SEEK_PULSE.
- Transitions and mode handling:
  - IDLE, with enable=1, goes to the state selected by mode on the next cycle.
  - A mode change in any non-busy state moves to the new mode's state next cycle and clears the dwell counter.
  - While busy=1, mode changes are ignored until the seek ends.
- Dwell counter: counts 0..dwell; an "event" fires on the cycle count==dwell, then wraps to 0. dwell=0 gives an event every cycle.
- MANUAL: sel_out=sel_in (registered, 1-cycle latency); button_out=synchronised edge pulse.
- AUTO: sel_out=1; button_out=1 for exactly the event cycle. With dwell=0, button_out is held at 1.
- BLINK: button_out=0; sel_out toggles on each event, starting from 0 on entry.
- SEEK mode, sel_out=1 throughout:
  - SEEK_IDLE: button_out=0.
  - seek_start with target in 1..6: latch target, clear err and step count, set busy=1, go to SEEK_WAIT.
  - seek_start with target 0 or 7: err=1 next cycle, no pulses, stay SEEK_IDLE.
  - SEEK_WAIT: wait SETTLE cycles, then compare colour_in with the latched target.
    - Equal: done=1 for one cycle, busy=0, back to SEEK_IDLE.
    - Not equal, step count==MAX_STEPS: err=1, busy=0, SEEK_IDLE.
    - Otherwise: SEEK_PULSE.
  - SEEK_PULSE: button_out=1 for one cycle, step count +1, back to SEEK_WAIT.
  - An already-matching colour completes with zero pulses.
  - seek_start while busy is ignored.
- Simultaneous events:
  - enable=0 beats everything.
  - seek_start and a mode change in the same cycle: the mode change wins; seek_start is dropped.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- rst=0 asserted mid-AUTO with button_out high → all outputs 0 immediately (asynchronous); after release with enable=1, mode=00 → sel_out follows sel_in with 1-cycle lag.
- MANUAL, btn_raw held high 50 cycles → exactly one button_out pulse, 3 cycles after the rise; no further pulses until btn_raw falls and rises again.
- AUTO, dwell=3 → button_out pulses every 4 cycles, sel_out=1. With dwell=0 → button_out constantly 1.
- BLINK, dwell=4 → sel_out pattern 0 for 5 cycles, 1 for 5 cycles, repeating; button_out stays 0.
- SEEK with a lights model at colour 2, target=5 → 3 pulses spaced SETTLE+1=3 cycles apart, then done pulse, busy drops, err=0. With target=2 → done after SETTLE cycles, zero pulses.
- SEEK with target=7 → err=1, no pulses. With a lights model stuck at colour 1, target=4 → 6 pulses, then err=1, busy=0. Next valid seek_start clears err.

Source files
------------

// File: rtl/light_sequencer.sv
// Mode controller for the lights selector: drives its button and sel inputs in
// manual pass-through, timed auto-advance, white/RGB blink and closed-loop colour seek.
module light_sequencer #(
  parameter int DW        = 24,
  parameter int SETTLE    = 2,
  parameter int MAX_STEPS = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic          btn_raw,
  input  logic          sel_in,
  input  logic [DW-1:0] dwell,
  input  logic          seek_start,
  input  logic [2:0]    target,
  input  logic [2:0]    colour_in,
  output logic          button_out,
  output logic          sel_out,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MANUAL, S_AUTO, S_BLINK, S_SEEK_IDLE, S_SEEK_WAIT, S_SEEK_PULSE
  } state_t;

  state_t        r_state;
  state_t        w_mode_state;
  logic [DW-1:0] r_cnt;
  logic [SW-1:0] r_steps;
  logic [WW-1:0] r_wait;
  logic [2:0]    r_target;
  logic          r_sync1, r_sync2, r_sync3;
  logic          r_button, r_sel, r_busy, r_done, r_err;
  logic [1:0]    w_state_mode;
  logic          w_mode_chg, w_event, w_edge, w_target_ok, w_entry_sel;

  // Mode encoding of the current state, and the state/sel to enter for the requested mode.
  always_comb begin
    w_state_mode = 2'b11;
    w_mode_state = S_SEEK_IDLE;
    w_entry_sel  = 1'b1;
    case (r_state)
      S_MANUAL: w_state_mode = 2'b00;
      S_AUTO:   w_state_mode = 2'b01;
      S_BLINK:  w_state_mode = 2'b10;
      default:  w_state_mode = 2'b11;
    endcase
    case (mode)
      2'b00:   begin w_mode_state = S_MANUAL;    w_entry_sel = sel_in; end
      2'b01:   begin w_mode_state = S_AUTO;      w_entry_sel = 1'b1;   end
      2'b10:   begin w_mode_state = S_BLINK;     w_entry_sel = 1'b0;   end
      default: begin w_mode_state = S_SEEK_IDLE; w_entry_sel = 1'b1;   end
    endcase
  end

  // A running seek (busy) locks out mode changes until it finishes.
  assign w_mode_chg  = (r_state != S_IDLE) && !r_busy && (mode != w_state_mode);
  assign w_event     = (r_cnt >= dwell);
  assign w_edge      = r_sync2 & ~r_sync3;
  assign w_target_ok = (target != 3'd0) && (target != 3'd7);

  // Sequencer: button synchroniser, dwell counter, mode FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {DW{1'b0}};
      r_steps  <= {SW{1'b0}};
      r_wait   <= {WW{1'b0}};
      r_target <= 3'd0;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_button <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (!enable) begin
      r_state  <= S_IDLE;
      r_cnt    <= {DW{1'b0}};
      r_steps  <= {SW{1'b0}};
      r_wait   <= {WW{1'b0}};
      r_target <= 3'd0;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_button <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_done  <= 1'b0;
      if ((r_state == S_IDLE) || w_mode_chg) begin
        r_state  <= w_mode_state;
        r_cnt    <= {DW{1'b0}};
        r_button <= 1'b0;
        r_sel    <= w_entry_sel;
      end else begin
        case (r_state)
          S_MANUAL: begin
            r_sel    <= sel_in;
            r_button <= w_edge;
          end
          S_AUTO: begin
            r_button <= w_event;
            r_cnt    <= w_event ? {DW{1'b0}} : r_cnt + DW'(1);
          end
          S_BLINK: begin
            r_button <= 1'b0;
            r_sel    <= w_event ? ~r_sel : r_sel;
            r_cnt    <= w_event ? {DW{1'b0}} : r_cnt + DW'(1);
          end
          S_SEEK_IDLE: begin
            r_button <= 1'b0;
            if (seek_start && w_target_ok) begin
              r_target <= target;
              r_err    <= 1'b0;
              r_steps  <= {SW{1'b0}};
              r_wait   <= {WW{1'b0}};
              r_busy   <= 1'b1;
              r_state  <= S_SEEK_WAIT;
            end else if (seek_start) begin
              r_err <= 1'b1;
            end
          end
          // Compare only once the lights and converter registers have caught up.
          S_SEEK_WAIT: begin
            if (r_wait == WW'(SETTLE - 1)) begin
              if (colour_in == r_target) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_SEEK_IDLE;
              end else if (r_steps == SW'(MAX_STEPS)) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_SEEK_IDLE;
              end else begin
                r_button <= 1'b1;
                r_state  <= S_SEEK_PULSE;
              end
            end else begin
              r_wait <= r_wait + WW'(1);
            end
          end
          S_SEEK_PULSE: begin
            r_button <= 1'b0;
            r_steps  <= r_steps + SW'(1);
            r_wait   <= {WW{1'b0}};
            r_state  <= S_SEEK_WAIT;
          end
          default: begin
            r_button <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign button_out = r_button;
  assign sel_out    = r_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
endmodule

// File: tb/tb_light_sequencer.sv
// Randomised self-checking bench for light_sequencer: a timeline-based reference
// model plus a small lights-counter environment that answers the seek.
module tb_light_sequencer;
  localparam int DW   = 24;
  localparam int S    = 2;
  localparam int MAXS = 6;

  logic          clk = 1'b0;
  logic          rst, enable, btn_raw, sel_in, seek_start;
  logic [1:0]    mode;
  logic [DW-1:0] dwell;
  logic [2:0]    target;
  logic [2:0]    colour_in = 3'd1;
  logic          button_out, sel_out, busy, done, err;

  logic [2:0]    light = 3'd1;
  logic          stuck, load_req;
  logic [2:0]    load_val;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  int first;

  // Reference model state: expected outputs plus the timeline of the current activity.
  bit       e_btn, e_sel, e_busy, e_done, e_err;
  bit       m_active, m_busy, m_ok;
  bit [1:0] m_mode;
  bit [2:0] hist;
  int       t = 0;
  int       entry, acc, end_rel;

  always #5 clk = ~clk;

  light_sequencer #(.DW(DW), .SETTLE(S), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .btn_raw(btn_raw),
    .sel_in(sel_in), .dwell(dwell), .seek_start(seek_start), .target(target),
    .colour_in(colour_in), .button_out(button_out), .sel_out(sel_out),
    .busy(busy), .done(done), .err(err)
  );

  // Lights counter (1..6 wrapping) followed by a registered converter stage.
  always @(posedge clk) begin
    if (load_req) light <= load_val;
    else if (button_out && !stuck) light <= (light == 3'd6) ? 3'd1 : light + 3'd1;
    colour_in <= light;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_busy   = 1'b0;
    hist     = 3'b000;
    e_btn = 1'b0; e_sel = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void enter();
    m_active = 1'b1;
    m_mode   = mode;
    entry    = t;
    e_btn    = 1'b0;
    e_sel    = (mode == 2'd0) ? sel_in : (mode != 2'd2);
  endfunction

  // Expected outputs after the coming clock edge, from the inputs now applied.
  function automatic void predict();
    bit pulse;
    int j, d, n;
    pulse = hist[1] & ~hist[2];
    t++;
    e_done = 1'b0;
    if (!enable) begin model_reset(); return; end
    hist = {hist[1:0], btn_raw};
    d = int'(dwell) + 1;
    if (!m_active) begin enter(); return; end
    if (m_busy) begin
      j = t - acc;
      if (j == end_rel) begin
        m_busy = 1'b0; e_busy = 1'b0; e_btn = 1'b0;
        if (m_ok) e_done = 1'b1;
        else e_err = 1'b1;
      end else begin
        e_btn = (j >= S) && (((j - S) % (S + 1)) == 0);
      end
      return;
    end
    if (mode != m_mode) begin enter(); return; end
    j = t - entry;
    case (m_mode)
      2'd0: begin e_sel = sel_in; e_btn = pulse; end
      2'd1: e_btn = ((j % d) == 0);
      2'd2: begin e_btn = 1'b0; e_sel = (((j / d) % 2) == 1); end
      default: begin
        e_btn = 1'b0;
        if (seek_start && (target inside {[3'd1:3'd6]})) begin
          if (stuck) n = (light == target) ? 0 : 99;
          else n = (int'(target) - int'(light) + 6) % 6;
          m_ok    = (n <= MAXS);
          end_rel = S + (m_ok ? n : MAXS) * (S + 1);
          acc     = t;
          m_busy  = 1'b1;
          e_busy  = 1'b1;
          e_err   = 1'b0;
        end else if (seek_start) begin
          e_err = 1'b1;
        end
      end
    endcase
  endfunction

  task automatic tick();
    predict();
    @(posedge clk);
    @(negedge clk);
    if (button_out) pulses++;
    chk("button_out", {31'd0, button_out}, {31'd0, e_btn});
    chk("sel_out",    {31'd0, sel_out},    {31'd0, e_sel});
    chk("busy",       {31'd0, busy},       {31'd0, e_busy});
    chk("done",       {31'd0, done},       {31'd0, e_done});
    chk("err",        {31'd0, err},        {31'd0, e_err});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic load(input logic [2:0] v, input logic stk);
    load_req = 1'b1; load_val = v; stuck = stk;
    tick();
    load_req = 1'b0;
  endtask

  task automatic seek(input logic [2:0] tgt);
    seek_start = 1'b1; target = tgt;
    tick();
    seek_start = 1'b0;
  endtask

  initial begin
    logic [1:0] nm;
    rst = 1'b0; enable = 1'b0; mode = 2'd0; btn_raw = 1'b0; sel_in = 1'b0;
    dwell = '0; seek_start = 1'b0; target = 3'd0; load_req = 1'b0; load_val = 3'd1; stuck = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_button", {31'd0, button_out}, 32'd0);
    chk("rst_sel",    {31'd0, sel_out},    32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_done",   {31'd0, done},       32'd0);
    chk("rst_err",    {31'd0, err},        32'd0);
    rst = 1'b1;
    run(2);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin sel_in = 1'($urandom); tick(); end

    // Held button: one pulse three cycles after the rise, none while held.
    btn_raw = 1'b1; pulses = 0; first = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (button_out && first < 0) first = k;
    end
    chk("manual_latency", first, 3);
    chk("manual_pulses", pulses, 1);
    btn_raw = 1'b0; run(5);
    btn_raw = 1'b1; run(6);
    btn_raw = 1'b0; run(3);

    mode = 2'd1; dwell = DW'(3); run(13);
    mode = 2'd2; dwell = DW'(4); run(22);
    mode = 2'd1; dwell = DW'(0); run(6);

    // Asynchronous reset while button_out is held high.
    chk("auto_hold", {31'd0, button_out}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_button", {31'd0, button_out}, 32'd0);
    chk("arst_sel",    {31'd0, sel_out},    32'd0);
    chk("arst_busy",   {31'd0, busy},       32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; mode = 2'd0;
    for (int k = 0; k < 6; k++) begin sel_in = 1'($urandom); tick(); end

    mode = 2'd3; run(2);
    load(3'd2, 1'b0); run(2);
    pulses = 0; seek(3'd5); run(14);
    chk("seek_pulses", pulses, 3);
    load(3'd2, 1'b0); run(2);
    pulses = 0; seek(3'd2); run(4);
    chk("seek_match_pulses", pulses, 0);
    pulses = 0; seek(3'd7); run(3);
    chk("seek_bad_err", {31'd0, err}, 32'd1);
    chk("seek_bad_pulses", pulses, 0);
    load(3'd1, 1'b1); run(2);
    pulses = 0; seek(3'd4); run(25);
    chk("seek_stuck_pulses", pulses, MAXS);
    chk("seek_stuck_err", {31'd0, err}, 32'd1);
    seek(3'd1); run(4);
    chk("seek_err_cleared", {31'd0, err}, 32'd0);
    load(3'd3, 1'b0); run(2);

    for (int i = 0; i < 600; i++) begin
      sel_in = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        nm = 2'($urandom_range(0, 3));
        if (nm != mode) begin mode = nm; dwell = DW'($urandom_range(0, 5)); end
      end
      seek_start = ($urandom_range(0, 7) == 0);
      target = 3'($urandom);
      if ($urandom_range(0, 4) == 0) btn_raw = ~btn_raw;
      enable = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
